// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch: instruction fetch stage of the 8-bit single-issue datapath.
//
// Holds the program counter and a 2**PC_W x INSTR_W instruction memory that is
// filled through a serial load port while the stage is idle. In RUN it
// presents one registered instruction per cycle to the decoder. The next PC
// comes from the decoder-resolved branch decision, subject to stall and the
// run/idle handshake.
//
// Optional feature macro: HALT_ON_SELF_BRANCH_EN
//   defined   - a taken branch-to-self (offset all ones) parks the stage in
//               HALT with o_halted=1 until i_run drops.
//   undefined - no HALT state; o_halted is tied to 0.
//
// Ports:
//   i_clk            rising-edge clock
//   i_reset_n        asynchronous active-low reset
//   i_load_en        write i_load_data to imem[i_load_addr] (IDLE/LOAD only)
//   i_load_addr      load write address
//   i_load_data      load write data
//   i_run            level: 1 = execute program, 0 = return to IDLE
//   i_stall          hold PC and instruction this cycle
//   i_branch_taken   current instruction is a taken branch
//   i_branch_offset  sign-extended branch displacement (two's complement)
//   o_pc             address of the instruction on o_instruction
//   o_instruction    registered instruction word to control/decode
//   o_instr_valid    o_instruction is a live fetched word
//   o_halted         self-branch halt reached
// -----------------------------------------------------------------------------
module instr_fetch #(
    parameter int unsigned          PC_W     = 8,
    parameter int unsigned          INSTR_W  = 8,
    parameter logic [PC_W-1:0]      RESET_PC = '0
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic               i_load_en,
    input  logic [PC_W-1:0]    i_load_addr,
    input  logic [INSTR_W-1:0] i_load_data,
    input  logic               i_run,
    input  logic               i_stall,
    input  logic               i_branch_taken,
    input  logic [PC_W-1:0]    i_branch_offset,
    output logic [PC_W-1:0]    o_pc,
    output logic [INSTR_W-1:0] o_instruction,
    output logic               o_instr_valid,
    output logic               o_halted
);

    localparam int unsigned     Depth = 1 << PC_W;
    localparam logic [PC_W-1:0] PcOne = {{(PC_W-1){1'b0}}, 1'b1};

`ifdef HALT_ON_SELF_BRANCH_EN
    typedef enum logic [1:0] {StIdle, StLoad, StRun, StHalt} state_e;
`else
    typedef enum logic [1:0] {StIdle, StLoad, StRun} state_e;
`endif

    state_e             r_state;
    state_e             w_state_d;
    logic [PC_W-1:0]    r_pc;
    logic [PC_W-1:0]    w_pc_d;
    logic [INSTR_W-1:0] r_instruction;
    logic               r_valid;
    logic               w_valid_d;
    logic               w_fetch;
    logic               w_mem_we;
    logic [PC_W-1:0]    w_pc_inc;
    logic [PC_W-1:0]    w_pc_branch;
    logic [INSTR_W-1:0] r_imem [Depth];

`ifdef HALT_ON_SELF_BRANCH_EN
    logic               r_halted;
    logic               w_halted_d;
    logic               w_self_branch;
`endif

    // Modulo-2**PC_W arithmetic; a negative offset wraps naturally.
    assign w_pc_inc    = r_pc + PcOne;
    assign w_pc_branch = w_pc_inc + i_branch_offset;

`ifdef HALT_ON_SELF_BRANCH_EN
    assign w_self_branch = i_branch_taken && (i_branch_offset == {PC_W{1'b1}});
`endif

    always_comb begin
        w_state_d = r_state;
        w_pc_d    = r_pc;
        w_valid_d = r_valid;
        w_fetch   = 1'b0;
        w_mem_we  = 1'b0;
`ifdef HALT_ON_SELF_BRANCH_EN
        w_halted_d = r_halted;
`endif
        unique case (r_state)
            StIdle: begin
                if (i_load_en) begin
                    w_state_d = StLoad;
                    w_mem_we  = 1'b1;
                end else if (i_run) begin
                    w_state_d = StRun;
                    w_pc_d    = RESET_PC;
                    w_fetch   = 1'b1;
                    w_valid_d = 1'b1;
                end
            end
            StLoad: begin
                if (i_load_en) begin
                    w_mem_we = 1'b1;
                end else begin
                    w_state_d = StIdle;
                end
            end
            StRun: begin
                // run=0 wins over stall and branch; pc/instruction hold.
                if (!i_run) begin
                    w_state_d = StIdle;
                    w_valid_d = 1'b0;
                end else if (!i_stall) begin
`ifdef HALT_ON_SELF_BRANCH_EN
                    if (w_self_branch) begin
                        w_state_d  = StHalt;
                        w_valid_d  = 1'b0;
                        w_halted_d = 1'b1;
                    end else begin
                        w_pc_d  = i_branch_taken ? w_pc_branch : w_pc_inc;
                        w_fetch = 1'b1;
                    end
`else
                    w_pc_d  = i_branch_taken ? w_pc_branch : w_pc_inc;
                    w_fetch = 1'b1;
`endif
                end
            end
`ifdef HALT_ON_SELF_BRANCH_EN
            StHalt: begin
                if (!i_run) begin
                    w_state_d  = StIdle;
                    w_halted_d = 1'b0;
                end
            end
`endif
            default: begin
                w_state_d = StIdle;
                w_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state       <= StIdle;
            r_pc          <= RESET_PC;
            r_instruction <= '0;
            r_valid       <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_pc    <= w_pc_d;
            r_valid <= w_valid_d;
            if (w_fetch) begin
                r_instruction <= r_imem[w_pc_d];
            end
        end
    end

`ifdef HALT_ON_SELF_BRANCH_EN
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_halted <= 1'b0;
        end else begin
            r_halted <= w_halted_d;
        end
    end
    assign o_halted = r_halted;
`else
    assign o_halted = 1'b0;
`endif

    // Memory contents survive reset, so no reset on this process.
    always_ff @(posedge i_clk) begin
        if (w_mem_we) begin
            r_imem[i_load_addr] <= i_load_data;
        end
    end

    assign o_pc          = r_pc;
    assign o_instruction = r_instruction;
    assign o_instr_valid = r_valid;

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
Instruction fetch stage of the 8-bit single-issue datapath. It sits directly upstream of the control/decode unit.
- Holds a program counter and an internal 256x8 instruction memory loaded through a serial load port.
- Presents one registered instruction per cycle; the decoder takes opcode bits [7:6] from it.
- Computes the next PC from the decoder-resolved branch decision, with stall and run/idle handshakes.

Parameters:
PC_W, 8, program counter and memory address width; memory depth is 2**PC_W
INSTR_W, 8, instruction width
RESET_PC, 0, PC value loaded at reset and on every IDLE->RUN entry

Ports:
clk  in  1  rising-edge clock
reset_n  in  1  asynchronous active-low reset
load_en  in  1  write load_data to imem[load_addr] this cycle (IDLE/LOAD only)
load_addr  in  PC_W  load write address
load_data  in  INSTR_W  load write data
run  in  1  level: 1 = execute program, 0 = return to IDLE
stall  in  1  hold PC and instruction this cycle
branch_taken  in  1  decoder/ALU: current instruction is a taken branch
branch_offset  in  PC_W  sign-extended branch displacement, two's complement
pc  out  PC_W  address of the instruction on `instruction`
instruction  out  INSTR_W  registered instruction word to the control/decode unit
instr_valid  out  1  instruction is a live fetched word
halted  out  1  self-branch halt reached (see Optional Feature)

Behaviour:
- Reset (async, reset_n=0): state=IDLE, pc=RESET_PC, instruction=0, instr_valid=0, halted=0. Memory contents are not reset.
- States: IDLE, LOAD, RUN, HALT (HALT exists only with the macro).
- IDLE:
  - load_en=1 -> LOAD; the write in that cycle is performed.
  - else run=1 -> RUN.
  - load_en takes priority over run.
- LOAD:
  - Each cycle with load_en=1: imem[load_addr] <= load_data.
  - load_en=0 -> IDLE.
  - run is ignored in LOAD.
- IDLE->RUN transition edge: pc <= RESET_PC, instruction <= imem[RESET_PC], instr_valid <= 1. First valid word therefore appears 1 cycle after run rises.
- RUN, stall=0: next_pc = branch_taken ? pc + 1 + branch_offset : pc + 1.
  - Arithmetic is modulo 2**PC_W: 8'hFF+1 wraps to 0; negative offsets wrap below 0.
  - Update: pc <= next_pc, instruction <= imem[next_pc].
- RUN, stall=1: pc, instruction and instr_valid held. branch_taken is ignored.
- RUN, run=0: -> IDLE next edge. instr_valid <= 0, pc and instruction hold their last values. run=0 takes priority over stall and branch_taken.
- RUN, load_en=1: ignored; memory is unchanged.
- Memory read is synchronous (registered into instruction). The same-address write-while-read case cannot occur because writes are blocked in RUN.
- Reset asserted mid-RUN or mid-LOAD: immediate return to reset values; a partial load keeps the words already written.

Optional Feature:
Macro HALT_ON_SELF_BRANCH_EN.
- Defined: in RUN, stall=0, branch_taken=1 and branch_offset=all ones (branch-to-self) -> HALT next edge.
  - pc and instruction keep their current values; instr_valid <= 0; halted <= 1.
  - HALT exits only on run=0 -> IDLE, with halted <= 0.
- Undefined: no HALT state; halted tied to 0. A self-branch keeps re-fetching the same address each cycle with instr_valid=1.

Test Plan:
- Reset then load imem[0..3]=8'h05,8'h46,8'h8B,8'h00 via load_en, then run=1 -> one cycle later pc=0, instruction=8'h05, valid=1; next cycles pc=1 instruction=8'h46, pc=2 instruction=8'h8B.
- Branch: at pc=2 assert branch_taken, offset=8'h03 -> next pc=6, instruction=imem[6]; offset=8'hFC at pc=6 -> pc=3.
- Wrap: load imem[255]=8'hAA and imem[0]=8'h11, drive execution to pc=255 with stall=0, no branch -> next pc=0, instruction=8'h11.
- Stall at pc=1 for 3 cycles with branch_taken=1 -> pc stays 1, instruction stays 8'h46, valid stays 1; release -> pc=2.
- run=0 mid-RUN at pc=4 -> IDLE, valid=0, pc=4; load_en pulse in RUN leaves memory unchanged. reset_n low mid-RUN -> pc=0, instruction=0, valid=0 without a clock edge.
- With HALT_ON_SELF_BRANCH_EN: at pc=3 branch_taken=1, offset=8'hFF -> halted=1, valid=0, pc=3; run=0 -> halted=0. Without the macro: pc stays 3, valid=1 every cycle.
